stopwatch_ctrl: RTL and testbench

Sequencing controller for the board's 0.1 s decimal count channel. It converts debounced single-cycle button pulses into a run/pause/clear state machine and owns the tick prescaler. It also produces the two BCD digits driven onto the DK1/DK0 display nibbles, and it stops at a programmable BCD limit. In DONE it blinks the display enable so the 7-segment driver flashes the final value. It sits between the debounce/edge-detect stage and the display control unit, replacing the ad-hoc toggle flip-flop plus free-running counter pair.

---
 rtl/stopwatch_ctrl.sv | 133 +++++++++++++
 tb/tb_stopwatch_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear sequencer for the 0.1 s BCD count channel, with tick prescaler and DONE blink.
// Latency: start/clear act at the sampling edge; run/done/count/disp_en are registered, tick is combinational.
// Backpressure: none; single-cycle pulses are consumed on the edge that samples them.
module stopwatch_ctrl #(
    parameter int         TICK_DIV    = 10_000_000,
    parameter logic [3:0] LIMIT_TEN   = 4'd3,
    parameter logic [3:0] LIMIT_UNIT  = 4'd0,
    parameter int         BLINK_TICKS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_pulse,
    input  logic       clear_pulse,
    output logic       run,
    output logic       done,
    output logic       tick,
    output logic [3:0] count_ten,
    output logic [3:0] count_unit,
    output logic       disp_en
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_TICKS - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    r_state;
    logic [PW-1:0] r_presc;
    logic [BW-1:0] r_blink;
    logic [3:0]    r_ten;
    logic [3:0]    r_unit;
    logic          r_run;
    logic          r_done;
    logic          r_disp_en;

    logic          w_wrap;
    logic          w_tick;
    logic [PW-1:0] w_presc_nxt;
    logic [3:0]    w_inc_ten;
    logic [3:0]    w_inc_unit;
    logic          w_hit_limit;

    // Prescaler wrap decode and the BCD value the count would take on a tick.
    always_comb begin
        w_wrap      = (r_presc == P_LAST);
        w_tick      = (r_state == S_RUN) && w_wrap && !clear_pulse;
        w_presc_nxt = w_wrap ? '0 : r_presc + PW'(1);
        if (r_unit == 4'd9) begin
            w_inc_unit = 4'd0;
            w_inc_ten  = r_ten + 4'd1;
        end else begin
            w_inc_unit = r_unit + 4'd1;
            w_inc_ten  = r_ten;
        end
        w_hit_limit = ({w_inc_ten, w_inc_unit} == {LIMIT_TEN, LIMIT_UNIT});
    end

    // State machine, prescaler, count and blink; clear behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (rst || clear_pulse) begin
            r_state   <= S_IDLE;
            r_presc   <= '0;
            r_blink   <= '0;
            r_ten     <= 4'd0;
            r_unit    <= 4'd0;
            r_run     <= 1'b0;
            r_done    <= 1'b0;
            r_disp_en <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_pulse) begin
                        r_state <= S_RUN;
                        r_presc <= '0;
                        r_run   <= 1'b1;
                    end
                end
                S_RUN: begin
                    // Prescaler advances even on the pausing edge so run cycles
                    // before and after a pause add up to one full tick period.
                    r_presc <= w_presc_nxt;
                    if (w_tick) begin
                        r_ten  <= w_inc_ten;
                        r_unit <= w_inc_unit;
                    end
                    if (w_tick && w_hit_limit) begin
                        r_state <= S_DONE;
                        r_presc <= '0;
                        r_blink <= '0;
                        r_run   <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (start_pulse) begin
                        r_state <= S_PAUSE;
                        r_run   <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    if (start_pulse) begin
                        r_state <= S_RUN;
                        r_run   <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_presc <= w_presc_nxt;
                    if (w_wrap) begin
                        if (r_blink == B_LAST) begin
                            r_blink   <= '0;
                            r_disp_en <= ~r_disp_en;
                        end else begin
                            r_blink <= r_blink + BW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign run        = r_run;
    assign done       = r_done;
    assign tick       = w_tick;
    assign count_ten  = r_ten;
    assign count_unit = r_unit;
    assign disp_en    = r_disp_en;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboarded bench for stopwatch_ctrl: directed scenarios then randomized pulses.
// Expected outputs per cycle come from an integer-valued reference model.
// A negedge monitor pops one expectation per cycle and compares all outputs.
module tb_stopwatch_ctrl;

    localparam int TD  = 4;
    localparam int BT  = 2;
    localparam int LIM = 12;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_pulse = 1'b0;
    logic       clear_pulse = 1'b0;
    logic       run, done, tick, disp_en;
    logic [3:0] count_ten, count_unit;

    stopwatch_ctrl #(
        .TICK_DIV   (TD),
        .LIMIT_TEN  (4'd1),
        .LIMIT_UNIT (4'd2),
        .BLINK_TICKS(BT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_pulse(start_pulse),
        .clear_pulse(clear_pulse),
        .run        (run),
        .done       (done),
        .tick       (tick),
        .count_ten  (count_ten),
        .count_unit (count_unit),
        .disp_en    (disp_en)
    );

    always #5 clk = ~clk;

    // Reference model: mode, decimal value, run cycles into the current tick
    // period, and cycles elapsed since DONE was entered.
    int m_mode     = M_IDLE;
    int m_val      = 0;
    int m_phase    = 0;
    int m_done_cyc = 0;

    logic [11:0] exp_q[$];
    int n_chk  = 0;
    int n_pass = 0;

    // One clock cycle: drive inputs, push this cycle's expected outputs, advance the model.
    task automatic cyc(input logic s, input logic c, input logic r);
        logic [11:0] e;
        @(posedge clk);
        #1;
        start_pulse = s;
        clear_pulse = c;
        rst         = r;
        e = {(m_mode == M_RUN),
             (m_mode == M_DONE),
             (m_mode == M_RUN && m_phase == TD - 1 && !c),
             4'(m_val / 10),
             4'(m_val % 10),
             ((m_mode != M_DONE) || (((m_done_cyc / (TD * BT)) % 2) == 0))};
        exp_q.push_back(e);
        if (r || c) begin
            m_mode = M_IDLE; m_val = 0; m_phase = 0; m_done_cyc = 0;
        end else begin
            case (m_mode)
                M_IDLE:  if (s) begin m_mode = M_RUN; m_phase = 0; end
                M_RUN: begin
                    if (m_phase == TD - 1) begin
                        m_phase = 0;
                        m_val++;
                        if (m_val == LIM) begin
                            m_mode = M_DONE; m_done_cyc = 0;
                        end else if (s) begin
                            m_mode = M_PAUSE;
                        end
                    end else begin
                        m_phase++;
                        if (s) m_mode = M_PAUSE;
                    end
                end
                M_PAUSE: if (s) m_mode = M_RUN;
                default: m_done_cyc++;
            endcase
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    // Run with no pulses until the model sits in RUN at the given value and prescaler phase.
    task automatic run_to(input int val, input int phase);
        int k;
        k = 0;
        while (!(m_mode == M_RUN && m_val == val && m_phase == phase) && k < 300) begin
            cyc(1'b0, 1'b0, 1'b0);
            k++;
        end
        if (k >= 300) begin
            n_chk++;
            $display("FAIL run_to: value %0d phase %0d not reached, model at value %0d phase %0d",
                     val, phase, m_val, m_phase);
        end
    endtask

    // Monitor: compare every output of the DUT against the queued expectation.
    always @(negedge clk) begin
        logic [11:0] e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {run, done, tick, count_ten, count_unit, disp_en};
            n_chk++;
            if (a !== e)
                $display("FAIL outputs t=%0t {run,done,tick,ten,unit,disp_en} got %b_%b_%b_%h_%h_%b want %b_%b_%b_%h_%h_%b",
                         $time, a[11], a[10], a[9], a[8:5], a[4:1], a[0],
                         e[11], e[10], e[9], e[8:5], e[4:1], e[0]);
            else
                n_pass++;
        end
    end

    initial begin
        int dens;
        // Reset then quiet IDLE.
        cyc(1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b1);
        idle(20);

        // Continuous run to the limit, blink in DONE, ignored starts, clear.
        cyc(1'b1, 1'b0, 1'b0);
        idle(70);
        cyc(1'b1, 1'b0, 1'b0);
        idle(5);
        cyc(1'b1, 1'b0, 1'b0);
        idle(9);
        cyc(1'b0, 1'b1, 1'b0);
        idle(4);

        // Pause after two run cycles, hold, resume.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        idle(10);
        cyc(1'b1, 1'b0, 1'b0);
        idle(6);
        cyc(1'b0, 1'b1, 1'b0);
        idle(2);

        // Start in the tick cycle at 05, then start+clear in a tick cycle.
        cyc(1'b1, 1'b0, 1'b0);
        run_to(5, TD - 1);
        cyc(1'b1, 1'b0, 1'b0);
        idle(5);
        cyc(1'b1, 1'b0, 1'b0);
        run_to(6, TD - 1);
        cyc(1'b1, 1'b1, 1'b0);
        idle(6);

        // Reset mid-RUN at 07 with prescaler 2, then restart.
        cyc(1'b1, 1'b0, 1'b0);
        run_to(7, 2);
        cyc(1'b0, 1'b0, 1'b1);
        idle(3);
        cyc(1'b1, 1'b0, 1'b0);
        idle(10);
        cyc(1'b0, 1'b1, 1'b0);

        // Randomized segments with varying pulse density.
        for (int seg = 0; seg < 12; seg++) begin
            dens = $urandom_range(3, 40);
            for (int i = 0; i < 250; i++)
                cyc(($urandom_range(0, dens - 1) == 0),
                    ($urandom_range(0, 79) == 0),
                    ($urandom_range(0, 399) == 0));
        end

        cyc(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        n_chk++;
        if (exp_q.size() != 0)
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        else
            n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
